// File: rtl/pc_fetch_unit_pkg.sv
// Shared constants and types for the fetch stage: PCSrc encodings, reset PC,
// bubble instruction and the fetch FSM state type.
package pc_fetch_unit_pkg;

    localparam logic [1:0] PCSRC_SEQ  = 2'b00;
    localparam logic [1:0] PCSRC_BR   = 2'b01;
    localparam logic [1:0] PCSRC_JALR = 2'b10;

    localparam logic [31:0] PC_RESET  = 32'h0040_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10
    } fetch_state_t;

endpackage

// File: rtl/pc_target_gen.sv
// Redirect target for branch/jal and jalr, plus the misaligned-target flag
// and a decode of whether PCSrc requests a redirect at all.
module pc_target_gen
    import pc_fetch_unit_pkg::*;
(
    input  logic [1:0]  PCSrc,
    input  logic [31:0] PC_E,
    input  logic [31:0] RD1_E,
    input  logic [31:0] ExtImm_E,
    output logic [31:0] target,
    output logic        misaligned,
    output logic        is_jump
);

    always_comb begin
        target  = PC_E + ExtImm_E;
        is_jump = 1'b0;
        case (PCSrc)
            PCSRC_BR: begin
                target  = PC_E + ExtImm_E;
                is_jump = 1'b1;
            end
            PCSRC_JALR: begin
                target  = (RD1_E + ExtImm_E) & ~32'h1;
                is_jump = 1'b1;
            end
            default: is_jump = 1'b0;
        endcase
        // Bit 0 is either architecturally cleared (jalr) or ignored; only bit 1 faults.
        misaligned = target[1];
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter, IF/ID pipeline register and BOOT/RUN/HALT control for the
// fetch stage of the pipelined RISC-V core.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] PC_RESET  = pc_fetch_unit_pkg::PC_RESET,
    parameter logic [31:0] NOP_INSTR = pc_fetch_unit_pkg::NOP_INSTR
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [1:0]  PCSrc,
    input  logic        Valid_E,
    input  logic [31:0] PC_E,
    input  logic [31:0] RD1_E,
    input  logic [31:0] ExtImm_E,
    input  logic        Stall_F,
    input  logic        Stall_D,
    input  logic [31:0] Instr_F,
    output logic [31:0] PC_F,
    output logic [31:0] Instr_D,
    output logic [31:0] PC_D,
    output logic [31:0] PCPlus4_D,
    output logic        Valid_D,
    output logic        Redirect,
    output logic        Halted
);

    fetch_state_t state_q, state_n;
    logic [31:0]  pc_q, pc_n;
    logic [31:0]  instr_q, instr_n;
    logic [31:0]  pcd_q, pcd_n;
    logic [31:0]  pc4_q, pc4_n;
    logic         valid_q, valid_n;
    logic [31:0]  target;
    logic         misaligned;
    logic         is_jump;

    pc_target_gen u_target (
        .PCSrc      (PCSrc),
        .PC_E       (PC_E),
        .RD1_E      (RD1_E),
        .ExtImm_E   (ExtImm_E),
        .target     (target),
        .misaligned (misaligned),
        .is_jump    (is_jump)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= BOOT;
            pc_q    <= PC_RESET;
            instr_q <= NOP_INSTR;
            pcd_q   <= '0;
            pc4_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_n;
            pc_q    <= pc_n;
            instr_q <= instr_n;
            pcd_q   <= pcd_n;
            pc4_q   <= pc4_n;
            valid_q <= valid_n;
        end
    end

    always_comb begin
        state_n  = state_q;
        pc_n     = pc_q;
        instr_n  = instr_q;
        pcd_n    = pcd_q;
        pc4_n    = pc4_q;
        valid_n  = valid_q;
        Redirect = 1'b0;
        case (state_q)
            BOOT: begin
                valid_n = 1'b0;
                state_n = RUN;
            end
            RUN: begin
                Redirect = Valid_E & is_jump;
                if (Redirect) begin
                    // Flush on any redirect; a faulting target freezes PC instead of loading it.
                    instr_n = NOP_INSTR;
                    valid_n = 1'b0;
                    if (misaligned) state_n = HALT;
                    else            pc_n    = target;
                end else begin
                    if (!Stall_F) pc_n = pc_q + 32'd4;
                    if (!Stall_D) begin
                        if (Stall_F) begin
                            instr_n = NOP_INSTR;
                            valid_n = 1'b0;
                        end else begin
                            instr_n = Instr_F;
                            pcd_n   = pc_q;
                            pc4_n   = pc_q + 32'd4;
                            valid_n = 1'b1;
                        end
                    end
                end
            end
            HALT: valid_n = 1'b0;
            default: state_n = BOOT;
        endcase
    end

    assign PC_F      = pc_q;
    assign Instr_D   = instr_q;
    assign PC_D      = pcd_q;
    assign PCPlus4_D = pc4_q;
    assign Valid_D   = valid_q;
    assign Halted    = (state_q == HALT);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed vector table plus randomized traffic for pc_fetch_unit, checked
// against a cycle-level behavioural model of the fetch stage.
module tb_pc_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] RST_PC = 32'h0040_0000;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [1:0]  PCSrc;
    logic        Valid_E;
    logic [31:0] PC_E, RD1_E, ExtImm_E;
    logic        Stall_F, Stall_D;
    logic [31:0] Instr_F;
    logic [31:0] PC_F, Instr_D, PC_D, PCPlus4_D;
    logic        Valid_D, Redirect, Halted;

    always #5 CLK = ~CLK;

    // Combinational ROM: data = 0xAAAA0000 + address
    assign Instr_F = 32'hAAAA_0000 + PC_F;

    pc_fetch_unit #(.PC_RESET(32'h0040_0000), .NOP_INSTR(32'h0000_0013)) dut (
        .CLK(CLK), .RESET(RESET), .PCSrc(PCSrc), .Valid_E(Valid_E),
        .PC_E(PC_E), .RD1_E(RD1_E), .ExtImm_E(ExtImm_E),
        .Stall_F(Stall_F), .Stall_D(Stall_D), .Instr_F(Instr_F),
        .PC_F(PC_F), .Instr_D(Instr_D), .PC_D(PC_D), .PCPlus4_D(PCPlus4_D),
        .Valid_D(Valid_D), .Redirect(Redirect), .Halted(Halted)
    );

    typedef struct {
        logic        rst;
        logic [1:0]  pcsrc;
        logic        ve;
        logic [31:0] pce, rd1, imm;
        logic        sf, sd;
        logic        exp_redir;
        logic [31:0] exp_pc;
        logic        exp_valid;
        logic        exp_halt;
    } vec_t;

    int nvec = 0;
    int nerr = 0;

    // Reference model: mode 0 = waiting one cycle after reset, 1 = fetching, 2 = stopped
    int          m_mode = 0;
    logic [31:0] m_pc = '0, m_instr = '0, m_pcd = '0, m_pc4 = '0;
    logic        m_valid = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic m_redirect(input vec_t v);
        return (m_mode == 1) && v.ve && (v.pcsrc == 2'd1 || v.pcsrc == 2'd2);
    endfunction

    task automatic model_step(input vec_t v);
        logic [31:0] tgt;
        logic [31:0] old_pc;
        if (v.rst) begin
            m_mode = 0; m_pc = RST_PC; m_instr = NOP; m_pcd = 0; m_pc4 = 0; m_valid = 0;
            return;
        end
        if (m_mode == 0) begin
            m_valid = 0;
            m_mode  = 1;
        end else if (m_mode == 1) begin
            old_pc = m_pc;
            if (m_redirect(v)) begin
                if (v.pcsrc == 2'd1) tgt = v.pce + v.imm;
                else begin
                    tgt = v.rd1 + v.imm;
                    tgt = tgt - (tgt % 2);
                end
                m_instr = NOP;
                m_valid = 0;
                if ((tgt / 4) * 4 != tgt - (tgt % 2)) m_mode = 2;
                else m_pc = tgt;
            end else begin
                if (!v.sf) m_pc = old_pc + 4;
                if (!v.sd) begin
                    if (v.sf) begin
                        m_instr = NOP;
                        m_valid = 0;
                    end else begin
                        m_instr = 32'hAAAA_0000 + old_pc;
                        m_pcd   = old_pc;
                        m_pc4   = old_pc + 4;
                        m_valid = 1;
                    end
                end
            end
        end else begin
            m_valid = 0;
        end
    endtask

    task automatic compare_model();
        chk("model.PC_F", PC_F, m_pc);
        chk("model.Instr_D", Instr_D, m_instr);
        chk("model.PC_D", PC_D, m_pcd);
        chk("model.PCPlus4_D", PCPlus4_D, m_pc4);
        chk("model.Valid_D", {31'd0, Valid_D}, {31'd0, m_valid});
        chk("model.Halted", {31'd0, Halted}, (m_mode == 2) ? 32'd1 : 32'd0);
    endtask

    task automatic apply(input vec_t v, input bit use_table);
        @(negedge CLK);
        RESET = v.rst; PCSrc = v.pcsrc; Valid_E = v.ve; PC_E = v.pce;
        RD1_E = v.rd1; ExtImm_E = v.imm; Stall_F = v.sf; Stall_D = v.sd;
        #1;
        chk("model.Redirect", {31'd0, Redirect}, {31'd0, m_redirect(v)});
        if (use_table) chk("tbl.Redirect", {31'd0, Redirect}, {31'd0, v.exp_redir});
        @(posedge CLK);
        model_step(v);
        #1;
        compare_model();
        if (use_table) begin
            chk("tbl.PC_F", PC_F, v.exp_pc);
            chk("tbl.Valid_D", {31'd0, Valid_D}, {31'd0, v.exp_valid});
            chk("tbl.Halted", {31'd0, Halted}, {31'd0, v.exp_halt});
        end
    endtask

    function automatic vec_t mk(input logic rst, input logic [1:0] pcsrc, input logic ve,
                                input logic [31:0] pce, input logic [31:0] rd1, input logic [31:0] imm,
                                input logic sf, input logic sd, input logic er,
                                input logic [31:0] ep, input logic ev, input logic eh);
        vec_t v;
        v.rst = rst; v.pcsrc = pcsrc; v.ve = ve; v.pce = pce; v.rd1 = rd1; v.imm = imm;
        v.sf = sf; v.sd = sd; v.exp_redir = er; v.exp_pc = ep; v.exp_valid = ev; v.exp_halt = eh;
        return v;
    endfunction

    vec_t tbl[$];
    vec_t rv;

    initial begin
        RESET = 1'b1; PCSrc = '0; Valid_E = 1'b0; PC_E = '0; RD1_E = '0; ExtImm_E = '0;
        Stall_F = 1'b0; Stall_D = 1'b0;

        //           rst pcsrc ve  pce            rd1            imm            sf sd  redir pc            v  h
        tbl.push_back(mk(1, 2'd0, 0, 32'h0,        32'h0,         32'h0,         0, 0, 0, 32'h0040_0000, 0, 0));
        tbl.push_back(mk(0, 2'd0, 0, 32'h0,        32'h0,         32'h0,         0, 0, 0, 32'h0040_0000, 0, 0));
        tbl.push_back(mk(0, 2'd0, 0, 32'h0,        32'h0,         32'h0,         0, 0, 0, 32'h0040_0004, 1, 0));
        tbl.push_back(mk(0, 2'd0, 0, 32'h0,        32'h0,         32'h0,         0, 0, 0, 32'h0040_0008, 1, 0));
        tbl.push_back(mk(0, 2'd1, 1, 32'h0040_0010, 32'h0,        32'hFFFF_FFF0, 0, 0, 1, 32'h0040_0000, 0, 0));
        tbl.push_back(mk(0, 2'd0, 0, 32'h0,        32'h0,         32'h0,         0, 0, 0, 32'h0040_0004, 1, 0));
        tbl.push_back(mk(0, 2'd2, 1, 32'h0,        32'h0040_0103, 32'h1,         0, 0, 1, 32'h0040_0104, 0, 0));
        tbl.push_back(mk(0, 2'd1, 0, 32'h0,        32'h0,         32'h100,       0, 0, 0, 32'h0040_0108, 1, 0));
        tbl.push_back(mk(0, 2'd0, 0, 32'h0,        32'h0,         32'h0,         1, 1, 0, 32'h0040_0108, 1, 0));
        tbl.push_back(mk(0, 2'd0, 0, 32'h0,        32'h0,         32'h0,         1, 1, 0, 32'h0040_0108, 1, 0));
        tbl.push_back(mk(0, 2'd0, 0, 32'h0,        32'h0,         32'h0,         1, 0, 0, 32'h0040_0108, 0, 0));
        tbl.push_back(mk(0, 2'd1, 1, 32'h0040_0020, 32'h0,        32'h20,        1, 0, 1, 32'h0040_0040, 0, 0));
        tbl.push_back(mk(0, 2'd0, 0, 32'h0,        32'h0,         32'h0,         0, 0, 0, 32'h0040_0044, 1, 0));
        tbl.push_back(mk(0, 2'd1, 1, 32'h0040_0000, 32'h0,        32'h2,         0, 0, 1, 32'h0040_0044, 0, 1));
        tbl.push_back(mk(0, 2'd0, 0, 32'h0,        32'h0,         32'h0,         0, 0, 0, 32'h0040_0044, 0, 1));
        tbl.push_back(mk(0, 2'd1, 1, 32'h0040_0000, 32'h0,        32'h40,        0, 0, 0, 32'h0040_0044, 0, 1));
        tbl.push_back(mk(0, 2'd0, 0, 32'h0,        32'h0,         32'h0,         0, 0, 0, 32'h0040_0044, 0, 1));
        tbl.push_back(mk(0, 2'd0, 0, 32'h0,        32'h0,         32'h0,         0, 0, 0, 32'h0040_0044, 0, 1));
        tbl.push_back(mk(0, 2'd0, 0, 32'h0,        32'h0,         32'h0,         0, 0, 0, 32'h0040_0044, 0, 1));
        tbl.push_back(mk(1, 2'd0, 0, 32'h0,        32'h0,         32'h0,         0, 0, 0, 32'h0040_0000, 0, 0));
        tbl.push_back(mk(0, 2'd0, 0, 32'h0,        32'h0,         32'h0,         0, 0, 0, 32'h0040_0000, 0, 0));
        tbl.push_back(mk(0, 2'd2, 1, 32'h0,        32'hFFFF_FFF0, 32'hC,         0, 0, 1, 32'hFFFF_FFFC, 0, 0));
        tbl.push_back(mk(0, 2'd0, 0, 32'h0,        32'h0,         32'h0,         0, 0, 0, 32'h0000_0000, 1, 0));
        tbl.push_back(mk(0, 2'd3, 1, 32'h0040_0000, 32'h0,        32'h100,       0, 0, 0, 32'h0000_0004, 1, 0));
        tbl.push_back(mk(0, 2'd0, 0, 32'h0,        32'h0,         32'h0,         0, 0, 0, 32'h0000_0008, 1, 0));
        tbl.push_back(mk(1, 2'd1, 1, 32'h0040_0100, 32'h0,        32'h0,         1, 1, 1, 32'h0040_0000, 0, 0));

        foreach (tbl[i]) apply(tbl[i], 1'b1);

        // Hand-written check: first fetched word after reset carries the reset PC
        apply(mk(0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        apply(mk(0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        chk("seq.PC_D_first", PC_D, 32'h0040_0000);
        chk("seq.Instr_D_first", Instr_D, 32'hAAAA_0000 + 32'h0040_0000);
        chk("seq.PCPlus4_D_first", PCPlus4_D, 32'h0040_0004);

        for (int n = 0; n < 400; n++) begin
            logic [31:0] mag;
            rv.rst   = ($urandom_range(0, 24) == 0);
            rv.pcsrc = 2'($urandom_range(0, 3));
            rv.ve    = ($urandom_range(0, 3) != 0);
            rv.pce   = 32'h0040_0000 + ($urandom_range(0, 255) << 2);
            rv.rd1   = $urandom;
            if ($urandom_range(0, 3) != 0) rv.rd1[1] = 1'b0;
            mag      = ($urandom_range(0, 3) == 0) ? ($urandom_range(0, 31) << 1)
                                                    : ($urandom_range(0, 31) << 2);
            rv.imm   = ($urandom_range(0, 1) == 0) ? mag : (32'd0 - mag);
            rv.sf    = ($urandom_range(0, 3) == 0);
            rv.sd    = ($urandom_range(0, 3) == 0);
            rv.exp_redir = 1'b0; rv.exp_pc = '0; rv.exp_valid = 1'b0; rv.exp_halt = 1'b0;
            apply(rv, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Fetch-side consumer of the PCSrc redirect decision produced by the branch/jump condition logic.
- Holds the program counter and drives the instruction-ROM address.
- Computes the redirect target from Execute-stage operands.
- Owns the IF/ID pipeline register, with stall, flush-on-redirect and a misaligned-target halt state.
- Sits between the instruction memory and the Decode stage of the pipelined RISC-V core.

Parameters:
- PC_RESET, 32'h00400000, PC value loaded on reset (IROM base).
- NOP_INSTR, 32'h00000013, instruction word injected into the IF/ID register on a bubble (addi x0,x0,0).

Ports:
- CLK  in  1  system clock, all state updates on rising edge.
- RESET  in  1  synchronous, active-high reset.
- PCSrc  in  2  from condition logic: 00 sequential, 01 branch/jal (PC_E+ExtImm_E), 10 jalr (RD1_E+ExtImm_E), 11 reserved.
- Valid_E  in  1  Execute-stage instruction is valid; redirect honoured only when 1.
- PC_E  in  32  PC of the Execute-stage instruction.
- RD1_E  in  32  rs1 value of the Execute-stage instruction (forwarded).
- ExtImm_E  in  32  sign-extended immediate of the Execute-stage instruction.
- Stall_F  in  1  hold PC (load-use hazard).
- Stall_D  in  1  hold IF/ID register.
- Instr_F  in  32  IROM read data for address PC_F (combinational ROM).
- PC_F  out  32  current fetch address to IROM.
- Instr_D  out  32  IF/ID instruction.
- PC_D  out  32  IF/ID PC.
- PCPlus4_D  out  32  IF/ID PC+4.
- Valid_D  out  1  IF/ID contents are a real instruction.
- Redirect  out  1  combinational: a redirect is being taken this cycle.
- Halted  out  1  high in HALT state.

Behaviour:
Reset
- Synchronous, active-high.
- PC_F=PC_RESET, Instr_D=NOP_INSTR, PC_D=0, PCPlus4_D=0, Valid_D=0, Halted=0, state=BOOT.

Target computation
- 32-bit modular adds; carry out discarded.
- Branch/jal target = PC_E+ExtImm_E.
- jalr target = (RD1_E+ExtImm_E) & ~32'h1.
- Redirect = Valid_E & (PCSrc==01 | PCSrc==10) & state==RUN.
- PCSrc==11 is treated as 00 (no redirect).

Misalignment
- A target with bit[1]=1 is a misaligned fault.
- Redirect still asserts, but PC_F is not updated, IF/ID is flushed, and state moves to HALT.

FSM
- BOOT: one cycle. Valid_D<=0, PC_F holds, state->RUN. The first real fetch is captured at the end of the next cycle.
- RUN: normal operation, priority highest first:
  - Fault: go to HALT.
  - Redirect: PC_F<=target; Instr_D<=NOP_INSTR, Valid_D<=0 (flush). Overrides Stall_F and Stall_D.
  - Stall_F: PC_F holds. Stall_D: IF/ID holds. The two apply independently.
  - Otherwise: PC_F<=PC_F+4; Instr_D<=Instr_F, PC_D<=PC_F, PCPlus4_D<=PC_F+4, Valid_D<=1.
  - Stall_F=1 with Stall_D=0: IF/ID loads a bubble (NOP, Valid_D=0).
- HALT: all state frozen, Valid_D=0, Halted=1. Only RESET exits.

Timing and boundaries
- Redirect latency: the target appears on PC_F one cycle after PCSrc is sampled; its instruction reaches Valid_D one cycle later.
- PC_F wrap: 32'hFFFFFFFC+4 = 0; no fault is raised.
- RESET asserted mid-operation (any state, any stall or redirect) wins unconditionally.

Decomposition:
- Shared package holds:
  - PCSrc encodings: PCSRC_SEQ=2'b00, PCSRC_BR=2'b01, PCSRC_JALR=2'b10.
  - NOP_INSTR and PC_RESET constants.
  - FSM state encoding: BOOT, RUN, HALT.
- One sub-module is natural: pc_target_gen, a combinational block computing the target and misalign flag.
- The PC register, IF/ID register and FSM stay in pc_fetch_unit.

Test Plan:
- Reset then 4 free-running cycles, ROM returning 32'hAAAA0000+addr → PC_F 0x00400000, 0x00400000 (BOOT), 0x00400004, 0x00400008. Valid_D goes 0,0,1,1 and PC_D=0x00400000 when Valid_D first rises.
- Branch: PCSrc=01, Valid_E=1, PC_E=0x00400010, ExtImm_E=0xFFFFFFF0 → Redirect=1, next PC_F=0x00400000, Valid_D=0, Instr_D=0x00000013.
- jalr: PCSrc=10, RD1_E=0x00400103, ExtImm_E=1 → PC_F=0x00400104 (bit0 cleared, no fault). PCSrc=01 with Valid_E=0 → no redirect.
- Stall: Stall_F=Stall_D=1 for 2 cycles → PC_F and IF/ID unchanged. Stall_F=1, Stall_D=0 → Valid_D=0. Stall_F=1 with a simultaneous valid branch → redirect taken.
- Misaligned: PCSrc=01, PC_E=0x00400000, ExtImm_E=2 → Halted=1, PC_F held, Valid_D=0 for 5+ cycles. RESET → PC_F=0x00400000, Halted=0.
- Wrap and reserved: force PC_F=0xFFFFFFFC → next PC_F=0. PCSrc=11 with Valid_E=1 → Redirect=0, sequential fetch.
